pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- pipeline control bundle between the pipeline datapath and
// the pipeline controller (pipe_ctrl).
//
// Parameter:
//   CNT_W  width of each performance counter
//
// Signals:
//   hazard, branch_taken, mem_req, sram_ready, clr_cnt  -> controller inputs
//   freeze_IF, flush_IF, flush_ID, freeze_all           <- pipeline controls
//   mem_timeout                                         <- sticky timeout error
//   stall_cnt, flush_cnt, wait_cnt_perf                 <- performance counters
//
// Modports:
//   master  pipeline side (drives the requests, receives the controls)
//   slave   controller side (pipe_ctrl)
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;
  logic             clr_cnt;
  logic             freeze_IF;
  logic             flush_IF;
  logic             flush_ID;
  logic             freeze_all;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt_perf;

  modport master (
    output hazard, branch_taken, mem_req, sram_ready, clr_cnt,
    input  freeze_IF, flush_IF, flush_ID, freeze_all, mem_timeout,
    input  stall_cnt, flush_cnt, wait_cnt_perf
  );

  modport slave (
    input  hazard, branch_taken, mem_req, sram_ready, clr_cnt,
    output freeze_IF, flush_IF, flush_ID, freeze_all, mem_timeout,
    output stall_cnt, flush_cnt, wait_cnt_perf
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline stall/flush/freeze controller with MEM-stage timeout.
//
// Freezes the whole pipeline while the MEM stage waits on the SRAM, stalls
// IF/ID on RAW hazards, flushes on taken branches, and traps into a sticky
// error state when a single memory wait lasts MAX_WAIT cycles.
//
// Parameters:
//   MAX_WAIT  consecutive MEM wait cycles that trigger the timeout
//   CNT_W     performance counter width
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   pipe_ctrl_if.slave (requests in, pipeline controls and counters out)
//
// Build option:
//   PIPE_PERF_CNT_EN  when defined, implements the saturating stall / flush /
//                     freeze-cycle counters; otherwise the counter outputs
//                     are tied to zero and clr_cnt is ignored.
module pipe_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] ONE_C      = WAIT_W'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_timeout_r;

  logic              mem_busy_s;
  logic              freeze_all_s;
  logic              freeze_if_s;
  logic              flush_if_s;
  logic              flush_id_s;
  logic [WAIT_W-1:0] wait_inc_s;

  // Pipeline control decode; a freeze masks hazard/branch, which the
  // upstream units keep presenting until the freeze is lifted.
  always_comb begin
    mem_busy_s   = bus.mem_req & ~bus.sram_ready;
    freeze_all_s = 1'b0;
    freeze_if_s  = 1'b0;
    flush_if_s   = 1'b0;
    flush_id_s   = 1'b0;
    if (state_r == ERR) begin
      freeze_all_s = 1'b1;
    end else begin
      freeze_all_s = mem_busy_s;
      freeze_if_s  = bus.hazard & ~bus.branch_taken & ~mem_busy_s;
      flush_if_s   = bus.branch_taken & ~mem_busy_s;
      flush_id_s   = (bus.branch_taken | bus.hazard) & ~mem_busy_s;
    end
  end

  assign wait_inc_s = wait_cnt_r + ONE_C;

  // Wait-tracking FSM: wait_cnt holds the number of wait cycles seen so far;
  // reaching MAX_WAIT moves to ERR, which only reset can leave.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_busy_s) begin
            wait_cnt_r <= ONE_C;
            if (MAX_WAIT_C == ONE_C) begin
              state_r       <= ERR;
              mem_timeout_r <= 1'b1;
            end else begin
              state_r <= MEM_WAIT;
            end
          end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
          end
        end
        MEM_WAIT: begin
          if (!mem_busy_s) begin
            state_r    <= RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else begin
            wait_cnt_r <= wait_inc_s;
            if (wait_inc_s == MAX_WAIT_C) begin
              state_r       <= ERR;
              mem_timeout_r <= 1'b1;
            end
          end
        end
        ERR: begin
          mem_timeout_r <= 1'b1;
        end
        default: begin
          state_r       <= RUN;
          wait_cnt_r    <= {WAIT_W{1'b0}};
          mem_timeout_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.freeze_IF   = freeze_if_s;
  assign bus.flush_IF    = flush_if_s;
  assign bus.flush_ID    = flush_id_s;
  assign bus.freeze_all  = freeze_all_s;
  assign bus.mem_timeout = mem_timeout_r;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] wait_perf_r;

  // Saturating performance counters; clr_cnt wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
      wait_perf_r <= {CNT_W{1'b0}};
    end else if (bus.clr_cnt) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
      wait_perf_r <= {CNT_W{1'b0}};
    end else begin
      if (freeze_if_s && (stall_cnt_r != CNT_MAX_C)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
      end
      if (flush_if_s && (flush_cnt_r != CNT_MAX_C)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE_C;
      end
      if (freeze_all_s && (wait_perf_r != CNT_MAX_C)) begin
        wait_perf_r <= wait_perf_r + CNT_ONE_C;
      end
    end
  end

  assign bus.stall_cnt     = stall_cnt_r;
  assign bus.flush_cnt     = flush_cnt_r;
  assign bus.wait_cnt_perf = wait_perf_r;
`else
  logic clr_cnt_unused_s;

  assign clr_cnt_unused_s  = bus.clr_cnt;
  assign bus.stall_cnt     = {CNT_W{1'b0}};
  assign bus.flush_cnt     = {CNT_W{1'b0}};
  assign bus.wait_cnt_perf = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (MAX_WAIT=8, CNT_W=4).
// Combines a decode table, hand-written multi-cycle sequences and random
// stimulus, all compared against a cycle-level reference model that tracks
// the run length of consecutive memory waits and saturating event counts.
module tb_pipe_ctrl;

  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  pipe_ctrl_if #(.CNT_W(CNT_W)) pif ();

  pipe_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  bit m_err;
  int m_run;
  int m_stall;
  int m_flush;
  int m_wperf;

  typedef struct packed {
    logic [3:0] in;   // {hazard, branch_taken, mem_req, sram_ready}
    logic [3:0] exp;  // {freeze_IF, flush_IF, flush_ID, freeze_all}
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic hz, input logic br, input logic mr,
                       input logic rdy, input logic clr);
    pif.hazard       = hz;
    pif.branch_taken = br;
    pif.mem_req      = mr;
    pif.sram_ready   = rdy;
    pif.clr_cnt      = clr;
  endtask

  task automatic model_reset();
    m_err   = 1'b0;
    m_run   = 0;
    m_stall = 0;
    m_flush = 0;
    m_wperf = 0;
  endtask

  task automatic model_outs(output bit fall, output bit fif,
                            output bit flif, output bit flid);
    bit busy;
    busy = pif.mem_req && !pif.sram_ready;
    fall = m_err ? 1'b1 : busy;
    fif  = !m_err && !busy && pif.hazard && !pif.branch_taken;
    flif = !m_err && !busy && pif.branch_taken;
    flid = !m_err && !busy && (pif.branch_taken || pif.hazard);
  endtask

  task automatic check_model(input string tag);
    bit fall, fif, flif, flid;
    model_outs(fall, fif, flif, flid);
    chk({tag, ".freeze_all"},  int'(pif.freeze_all),  int'(fall));
    chk({tag, ".freeze_IF"},   int'(pif.freeze_IF),   int'(fif));
    chk({tag, ".flush_IF"},    int'(pif.flush_IF),    int'(flif));
    chk({tag, ".flush_ID"},    int'(pif.flush_ID),    int'(flid));
    chk({tag, ".mem_timeout"}, int'(pif.mem_timeout), int'(m_err));
    chk({tag, ".stall_cnt"},   int'(pif.stall_cnt),     PERF ? m_stall : 0);
    chk({tag, ".flush_cnt"},   int'(pif.flush_cnt),     PERF ? m_flush : 0);
    chk({tag, ".wait_perf"},   int'(pif.wait_cnt_perf), PERF ? m_wperf : 0);
  endtask

  // advance the model across one rising edge with rst high
  task automatic model_edge();
    bit fall, fif, flif, flid;
    model_outs(fall, fif, flif, flid);
    if (pif.clr_cnt) begin
      m_stall = 0;
      m_flush = 0;
      m_wperf = 0;
    end else begin
      if (fif  && m_stall < CMAX) m_stall++;
      if (flif && m_flush < CMAX) m_flush++;
      if (fall && m_wperf < CMAX) m_wperf++;
    end
    if (!m_err) begin
      if (fall) begin
        m_run++;
        if (m_run >= MAX_WAIT) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // called shortly after a rising edge: check, cross the next edge, settle
  task automatic step(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{in: 4'b0000, exp: 4'b0000};
    tbl[1]  = '{in: 4'b0001, exp: 4'b0000};
    tbl[2]  = '{in: 4'b0010, exp: 4'b0001};
    tbl[3]  = '{in: 4'b0011, exp: 4'b0000};
    tbl[4]  = '{in: 4'b0100, exp: 4'b0110};
    tbl[5]  = '{in: 4'b0101, exp: 4'b0110};
    tbl[6]  = '{in: 4'b0110, exp: 4'b0001};
    tbl[7]  = '{in: 4'b0111, exp: 4'b0110};
    tbl[8]  = '{in: 4'b1000, exp: 4'b1010};
    tbl[9]  = '{in: 4'b1001, exp: 4'b1010};
    tbl[10] = '{in: 4'b1010, exp: 4'b0001};
    tbl[11] = '{in: 4'b1011, exp: 4'b1010};
    tbl[12] = '{in: 4'b1100, exp: 4'b0110};
    tbl[13] = '{in: 4'b1101, exp: 4'b0110};
    tbl[14] = '{in: 4'b1110, exp: 4'b0001};
    tbl[15] = '{in: 4'b1111, exp: 4'b0110};

    // power-on reset; outputs follow the RUN decode while held in reset
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_model("por");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("por_hazard.freeze_IF", int'(pif.freeze_IF), 1);
    check_model("por_hazard");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // decode table
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], 1'b0);
      #1;
      chk("tbl.freeze_IF",  int'(pif.freeze_IF),  int'(tbl[i].exp[3]));
      chk("tbl.flush_IF",   int'(pif.flush_IF),   int'(tbl[i].exp[2]));
      chk("tbl.flush_ID",   int'(pif.flush_ID),   int'(tbl[i].exp[1]));
      chk("tbl.freeze_all", int'(pif.freeze_all), int'(tbl[i].exp[0]));
      step("tbl");
    end

    // two-cycle hazard stall
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("stall.freeze_IF", int'(pif.freeze_IF), 1);
      chk("stall.flush_ID",  int'(pif.flush_ID),  1);
      chk("stall.flush_IF",  int'(pif.flush_IF),  0);
      step("stall");
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("stall_end.freeze_IF", int'(pif.freeze_IF), 0);
    chk("stall.stall_cnt", int'(pif.stall_cnt), PERF ? 2 : 0);
    step("stall_end");

    // branch overrides hazard
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("br.freeze_IF", int'(pif.freeze_IF), 0);
    chk("br.flush_IF",  int'(pif.flush_IF),  1);
    chk("br.flush_ID",  int'(pif.flush_ID),  1);
    step("br");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("br.flush_cnt", int'(pif.flush_cnt), PERF ? 1 : 0);
    step("br_end");

    // four-cycle memory wait with a hazard held throughout
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("mw.freeze_all", int'(pif.freeze_all), 1);
      chk("mw.freeze_IF",  int'(pif.freeze_IF),  0);
      step("mw");
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("mw_rel.freeze_all", int'(pif.freeze_all), 0);
    chk("mw_rel.freeze_IF",  int'(pif.freeze_IF),  1);
    step("mw_rel");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mw.wait_perf", int'(pif.wait_cnt_perf), PERF ? 4 : 0);
    chk("mw.stall_cnt", int'(pif.stall_cnt),     PERF ? 1 : 0);
    step("mw_end");

    // timeout after MAX_WAIT wait cycles, sticky until reset
    do_reset();
    for (int i = 0; i < MAX_WAIT; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("to_wait.mem_timeout", int'(pif.mem_timeout), 0);
      step("to_wait");
    end
    chk("to.mem_timeout", int'(pif.mem_timeout), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("err.freeze_all", int'(pif.freeze_all), 1);
      chk("err.flush_IF",   int'(pif.flush_IF),   0);
      chk("err.mem_timeout", int'(pif.mem_timeout), 1);
      step("err");
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("err_rst.mem_timeout", int'(pif.mem_timeout), 0);
    chk("err_rst.freeze_all",  int'(pif.freeze_all),  0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // reset asserted in the third wait cycle
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mid1");
    step("mid2");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst.freeze_all", int'(pif.freeze_all), 1);
    chk("mid_rst.wait_perf",  int'(pif.wait_cnt_perf), 0);
    chk("mid_rst.stall_cnt",  int'(pif.stall_cnt), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mid_rst.no_freeze", int'(pif.freeze_all), 0);
    chk("mid_rst.freeze_IF", int'(pif.freeze_IF),  1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("mid_after");

    // saturation and clear
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("sat");
    #1;
    chk("sat.stall_cnt", int'(pif.stall_cnt), PERF ? 15 : 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("clr");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("clr.stall_cnt", int'(pif.stall_cnt), 0);
    step("clr_after");
    #1;
    chk("clr_after.stall_cnt", int'(pif.stall_cnt), PERF ? 1 : 0);

    // random stimulus against the reference model
    begin
      int thr;
      thr = 3;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) thr = $urandom_range(0, 6);
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 9) < thr,
              $urandom_range(0, 15) == 0);
        if ($urandom_range(0, 149) == 0) begin
          rst = 1'b0;
          model_reset();
          #1;
          check_model("rnd_rst");
          @(posedge clk);
          #1;
          rst = 1'b1;
        end else begin
          step("rnd");
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
